// File: rtl/blinky_sim_pkg.sv
// Shared constants and state type for the UART echo top and its rx/tx engines.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blinky_sim_pkg;

    // 32.256 MHz / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 280;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle rx_valid_o pulse.
// Latency: rx_valid_o about 9.5 bit times plus 2 sync cycles after the start edge.
// Backpressure: none; the byte is presented for one cycle only, and framing errors are dropped.
module uart_rx
    import blinky_sim_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  sync_q;
    logic        rxs;
    uart_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    assign rxs = sync_q[1];

    // Synchronizer, preset to line-idle so reset never looks like a start bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx_i};
    end

    // Frame sequencing; ferr_q parks the FSM in STOP until the line goes high again
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            IDLE: begin
                ferr_d = 1'b0;
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (ferr_q) begin
                    if (rxs) state_d = IDLE;
                end else if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = data_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a flopped, glitch-free tx_o.
// Latency: start bit appears on tx_o the cycle after a tx_valid_i/tx_ready_o handshake.
// Backpressure: tx_ready_o high when idle and in the last stop-bit cycle, allowing gapless frames.
module uart_tx
    import blinky_sim_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_o
);

    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    uart_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        take;

    assign tx_ready_o = (state_q == IDLE) || ((state_q == STOP) && (cnt_q == FULL_M1));
    assign take       = tx_valid_i && tx_ready_o;

    // Next line level is computed with the next state so tx_o comes straight from a flop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (take) begin
                    state_d = START;
                    cnt_d   = '0;
                    shift_d = tx_data_i;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (cnt_q == FULL_M1) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (take) begin
                        state_d = START;
                        shift_d = tx_data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Transmitter state registers; line presets high so reset releases it immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/blinky_sim_echo.sv
// UART echo top: rx engine -> one-byte holding register -> tx engine.
// Latency: tx start bit 2 cycles after rx_valid (hold load, then tx launch).
// Backpressure: a byte arriving while the holding register stays full is dropped.
module blinky_sim_echo
    import blinky_sim_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic tx_o
);

    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 tx_ready;
    logic                 take;
    logic                 load;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_dat_q, hold_dat_d;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tx_valid_i (hold_full_q),
        .tx_data_i  (hold_dat_q),
        .tx_ready_o (tx_ready),
        .tx_o       (tx_o)
    );

    assign take = hold_full_q && tx_ready;
    // A byte vacating in the same cycle frees the slot, so the new byte lands and wins
    assign load = rx_valid && (!hold_full_q || take);

    // Holding register occupancy and data
    always_comb begin
        hold_full_d = load || (hold_full_q && !take);
        hold_dat_d  = load ? rx_data : hold_dat_q;
    end

    // Holding register flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_full_q <= 1'b0;
            hold_dat_q  <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_dat_q  <= hold_dat_d;
        end
    end

endmodule

// File: tb/tb_blinky_sim_echo.sv
// Randomized echo bench: drives 8N1 frames, predicts each echo's byte and start cycle,
// and checks tx_o bit-by-bit against the prediction on every cycle of every frame.
module tb_blinky_sim_echo;

    localparam int CPB = 280;
    // edge that samples the rx fall + 2 sync + mid stop bit (9.5 bits) + 2 cycles to tx start
    localparam int EXP_LAT = 1 + 2 + CPB / 2 + 9 * CPB + 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic rx_i  = 1'b1;
    logic tx_o;

    blinky_sim_echo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx_i  (rx_i),
        .tx_o  (tx_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  b;
        int unsigned t;
    } exp_t;
    exp_t expq[$];

    bit          mon_active = 1'b0;
    int          mon_idx    = 0;
    logic [7:0]  mon_byte   = 8'h00;
    logic [7:0]  mon_dec    = 8'h00;
    bit          bit_err    = 1'b0;
    int          frames     = 0;
    int unsigned last_start = 0;
    int unsigned last_send  = 0;
    logic [7:0]  last_byte  = 8'h00;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: frames decoded from tx_o and compared against the expected queue
    always @(negedge clk_i) begin
        exp_t e;
        int   fb;
        int   pos;
        logic expbit;
        if (rst_i) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx_o == 1'b0) begin
                mon_active = 1'b1;
                mon_idx    = 0;
                bit_err    = 1'b0;
                frames++;
                last_start = cyc;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    mon_byte = 8'h00;
                    $display("FAIL unexpected_frame: got start bit at cycle %0d want idle line", cyc);
                end else begin
                    e        = expq.pop_front();
                    mon_byte = e.b;
                    check("start_time", cyc, e.t);
                end
            end
            if (mon_active) begin
                fb     = mon_idx / CPB;
                pos    = mon_idx % CPB;
                expbit = (fb == 0) ? 1'b0 : (fb == 9) ? 1'b1 : mon_byte[fb-1];
                if (tx_o !== expbit) bit_err = 1'b1;
                if (pos == CPB / 2 && fb >= 1 && fb <= 8) mon_dec[fb-1] = tx_o;
                if (pos == CPB - 1) begin
                    check($sformatf("frame_bit%0d", fb), bit_err, 0);
                    bit_err = 1'b0;
                end
                mon_idx++;
                if (mon_idx == 10 * CPB) begin
                    mon_active = 1'b0;
                    last_byte  = mon_dec;
                    check("echo_byte", mon_dec, mon_byte);
                end
            end
        end
    end

    // Drive one frame; returns on the edge that ends the stop bit so frames can abut
    task automatic send_byte(input logic [7:0] b, input bit good_stop, input bit expect_echo);
        exp_t e;
        @(posedge clk_i);
        #1;
        rx_i      = 1'b0;
        last_send = cyc;
        if (expect_echo) begin
            e.b = b;
            e.t = cyc + EXP_LAT;
            expq.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk_i);
            #1;
            rx_i = b[i];
        end
        repeat (CPB) @(posedge clk_i);
        #1;
        rx_i = good_stop;
        repeat (CPB - 1) @(posedge clk_i);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk_i);
            if (expq.size() == 0 && !mon_active) begin
                done = 1'b1;
                break;
            end
        end
        check(name, done, 1);
    endtask

    task automatic idle_check(input string name, input int n);
        bit seen_low;
        seen_low = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1) seen_low = 1'b1;
        end
        check(name, seen_low, 0);
    endtask

    initial begin
        int f0;
        bit reached;
        logic [7:0] rb;
        int gap;

        // Reset held with line idle
        rx_i  = 1'b1;
        rst_i = 1'b1;
        idle_check("reset_tx_high", 100);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_check("post_reset_idle", 1000);

        // Single byte 0x41
        f0 = frames;
        send_byte(8'h41, 1'b1, 1'b1);
        wait_drain("single_drain");
        check("single_frames", frames, f0 + 1);
        check("single_byte", last_byte, 8'h41);
        check("single_latency", last_start - last_send, 2665);
        idle_check("single_after", 50);

        // Back-to-back, no gap
        f0 = frames;
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h55, 1'b1, 1'b1);
        wait_drain("b2b_drain");
        check("b2b_frames", frames, f0 + 3);
        check("b2b_last", last_byte, 8'h55);

        // Glitch shorter than half a bit
        f0 = frames;
        @(posedge clk_i);
        #1;
        rx_i = 1'b0;
        repeat (50) @(posedge clk_i);
        #1;
        rx_i = 1'b1;
        idle_check("glitch_idle", 3000);
        check("glitch_frames", frames, f0);

        // Framing error then a good byte
        f0 = frames;
        send_byte(8'hA5, 1'b0, 1'b0);
        #1;
        rx_i = 1'b1;
        repeat (400) @(posedge clk_i);
        send_byte(8'h3C, 1'b1, 1'b1);
        wait_drain("ferr_drain");
        check("ferr_frames", frames, f0 + 1);
        check("ferr_byte", last_byte, 8'h3C);

        // Random bytes with random gaps, some back-to-back
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 300));
            send_byte(rb, 1'b1, 1'b1);
            repeat (gap) @(posedge clk_i);
        end
        wait_drain("rand_drain");
        check("rand_frames", frames, f0 + 6);

        // Reset in the middle of echoing data bit 3
        send_byte(8'h41, 1'b1, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_i);
            if (mon_active && mon_idx >= 4 * CPB + 100) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_bit3", reached, 1);
        f0 = frames;
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_tx_high", tx_o, 1);
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_check("rst_mid_after", 3000);
        check("rst_mid_frames", frames, f0);
        check("rst_mid_queue", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
